// File: rtl/axi_scratchpad_responder_if.sv
// AXI4 (+AXI5 atop) slave port bundle for the scratchpad responder.
interface axi_scratchpad_responder_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] awid;
  logic [63:0]         awaddr;
  logic [7:0]          awlen;
  logic [5:0]          awatop;
  logic                awvalid;
  logic                awready;
  logic [63:0]         wdata;
  logic [7:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] arid;
  logic [63:0]         araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [63:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awatop, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awatop, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_scratchpad_responder.sv
// Single-outstanding AXI scratchpad: 64-bit word memory, INCR bursts,
// atomics answered with SLVERR on both B and R.
module axi_scratchpad_responder #(
  parameter int ID_WIDTH  = 4,
  parameter int MEM_WORDS = 512
) (
  input logic clock_i,
  input logic reset_i,
  axi_scratchpad_responder_if.slave s_axi
);
  localparam int IW = $clog2(MEM_WORDS);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_ATOP_R
  } state_t;

  state_t              r_state;
  logic [ID_WIDTH-1:0] r_id;
  logic [IW-1:0]       r_idx;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [5:0]          r_atop;
  logic                r_oor;
  logic                r_bvalid;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [ID_WIDTH-1:0] r_rid;
  logic [63:0]         r_rdata;
  logic [1:0]          r_rresp;
  logic                r_rlast;

  logic [63:0] r_mem [MEM_WORDS];

  logic          w_idle;
  logic          w_aw_oor;
  logic          w_ar_oor;
  logic [IW-1:0] w_aw_idx;
  logic [IW-1:0] w_ar_idx;
  logic          w_wr_en;
  logic          w_unused_ok;

  assign w_idle   = (r_state == S_IDLE) && !reset_i;
  assign w_aw_oor = |s_axi.awaddr[63:IW+3];
  assign w_ar_oor = |s_axi.araddr[63:IW+3];
  assign w_aw_idx = s_axi.awaddr[IW+2:3];
  assign w_ar_idx = s_axi.araddr[IW+2:3];

  assign w_unused_ok = ^{s_axi.awaddr[2:0], s_axi.araddr[2:0]};

  // AW wins a tie: AR is only offered while no AW is pending
  assign s_axi.awready = w_idle;
  assign s_axi.arready = w_idle && !s_axi.awvalid;
  assign s_axi.wready  = (r_state == S_WRITE) && !reset_i;

  assign s_axi.bvalid = r_bvalid;
  assign s_axi.bid    = r_bid;
  assign s_axi.bresp  = r_bresp;
  assign s_axi.rvalid = r_rvalid;
  assign s_axi.rid    = r_rid;
  assign s_axi.rdata  = r_rdata;
  assign s_axi.rresp  = r_rresp;
  assign s_axi.rlast  = r_rlast;

  assign w_wr_en = s_axi.wready && s_axi.wvalid &&
                   (r_atop == 6'd0) && !r_oor;

  // Memory has no reset so contents survive reset_i
  always_ff @(posedge clock_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi.wstrb[b]) begin
          r_mem[r_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_id     <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_atop   <= '0;
      r_oor    <= 1'b0;
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= OKAY;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
      r_rlast  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (s_axi.awvalid) begin
            r_id    <= s_axi.awid;
            r_idx   <= w_aw_idx;
            r_len   <= s_axi.awlen;
            r_atop  <= s_axi.awatop;
            r_oor   <= w_aw_oor;
            r_state <= S_WRITE;
          end else if (s_axi.arvalid) begin
            r_id     <= s_axi.arid;
            r_idx    <= w_ar_idx + 1'b1;
            r_len    <= s_axi.arlen;
            r_cnt    <= '0;
            r_oor    <= w_ar_oor;
            r_rvalid <= 1'b1;
            r_rid    <= s_axi.arid;
            r_rdata  <= w_ar_oor ? 64'd0 : r_mem[w_ar_idx];
            r_rresp  <= w_ar_oor ? DECERR : OKAY;
            r_rlast  <= (s_axi.arlen == 8'd0);
            r_state  <= S_READ;
          end
        end
        S_WRITE: begin
          if (s_axi.wvalid) begin
            r_idx <= r_idx + 1'b1;
            if (s_axi.wlast) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= r_oor ? DECERR :
                          (r_atop != 6'd0) ? SLVERR : OKAY;
              r_state  <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (s_axi.bready) begin
            r_bvalid <= 1'b0;
            if (r_atop[5]) begin
              r_rvalid <= 1'b1;
              r_rid    <= r_id;
              r_rdata  <= '0;
              r_rresp  <= SLVERR;
              r_rlast  <= (r_len == 8'd0);
              r_cnt    <= '0;
              r_state  <= S_ATOP_R;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_READ, S_ATOP_R: begin
          if (s_axi.rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              if (r_state == S_READ) begin
                r_rdata <= r_oor ? 64'd0 : r_mem[r_idx];
              end
              r_idx   <= r_idx + 1'b1;
              r_cnt   <= r_cnt + 8'd1;
              r_rlast <= (r_cnt + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_scratchpad_responder.sv
// Directed bench for axi_scratchpad_responder with a 16-word memory
// (out-of-range boundary at byte 0x80).
module tb_axi_scratchpad_responder;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;
  localparam logic [1:0] DE = 2'b11;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [63:0] wbuf [8];
  logic [7:0]  sbuf [8];
  logic [63:0] ebuf [8];

  axi_scratchpad_responder_if #(.ID_WIDTH(4)) s_axi ();

  axi_scratchpad_responder #(
    .ID_WIDTH (4),
    .MEM_WORDS(16)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .s_axi  (s_axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic wr(input logic [3:0]  id,
                    input logic [63:0] addr,
                    input logic [7:0]  len,
                    input logic [5:0]  atop,
                    input logic [1:0]  er,
                    input bit          rnd);
    int t;
    bit hs;
    bit held;
    logic [3:0] hi;
    logic [1:0] hr;
    s_axi.awvalid = 1'b1;
    s_axi.awid    = id;
    s_axi.awaddr  = addr;
    s_axi.awlen   = len;
    s_axi.awatop  = atop;
    t = 0;
    hs = 0;
    while (!hs && t < 100) begin
      @(negedge clk);
      hs = s_axi.awready;
      if (hs && s_axi.arvalid) chk("ar_held_off", s_axi.arready, 0);
      @(posedge clk); #1;
      t++;
    end
    s_axi.awvalid = 1'b0;
    if (!hs) timeout("aw_hs");
    for (int b = 0; b <= int'(len); b++) begin
      s_axi.wvalid = 1'b1;
      s_axi.wdata  = wbuf[b];
      s_axi.wstrb  = sbuf[b];
      s_axi.wlast  = (b == int'(len));
      t = 0;
      hs = 0;
      while (!hs && t < 100) begin
        @(negedge clk);
        hs = s_axi.wready;
        @(posedge clk); #1;
        t++;
      end
      if (!hs) timeout("w_hs");
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    s_axi.bready = rnd ? 1'($urandom % 2) : 1'b1;
    t = 0;
    hs = 0;
    held = 0;
    while (!hs && t < 200) begin
      @(negedge clk);
      if (s_axi.bvalid) begin
        if (held) begin
          chk("b_stable_id", s_axi.bid, hi);
          chk("b_stable_resp", s_axi.bresp, hr);
        end
        if (s_axi.bready) begin
          chk("bid", s_axi.bid, id);
          chk("bresp", s_axi.bresp, er);
          hs = 1;
        end else begin
          held = 1;
          hi = s_axi.bid;
          hr = s_axi.bresp;
        end
      end
      @(posedge clk); #1;
      t++;
      s_axi.bready = rnd ? 1'($urandom % 2) : 1'b1;
    end
    s_axi.bready = 1'b0;
    if (!hs) timeout("b_hs");
  endtask

  task automatic rd(input logic [3:0]  id,
                    input logic [63:0] addr,
                    input logic [7:0]  len,
                    input logic [1:0]  er,
                    input bit          rnd,
                    input bit          skip_ar);
    int t;
    int beat;
    bit hs;
    bit held;
    logic [63:0] hd;
    logic [3:0]  hi;
    logic [1:0]  hr;
    logic        hl;
    if (!skip_ar) begin
      s_axi.arvalid = 1'b1;
      s_axi.arid    = id;
      s_axi.araddr  = addr;
      s_axi.arlen   = len;
      t = 0;
      hs = 0;
      while (!hs && t < 100) begin
        @(negedge clk);
        hs = s_axi.arready;
        @(posedge clk); #1;
        t++;
      end
      s_axi.arvalid = 1'b0;
      if (!hs) timeout("ar_hs");
    end
    beat = 0;
    held = 0;
    t = 0;
    s_axi.rready = rnd ? 1'($urandom % 2) : 1'b1;
    while (beat <= int'(len) && t < 200) begin
      @(negedge clk);
      if (s_axi.rvalid) begin
        if (held) begin
          chk("r_stable_data", s_axi.rdata, hd);
          chk("r_stable_id", s_axi.rid, hi);
          chk("r_stable_resp", s_axi.rresp, hr);
          chk("r_stable_last", s_axi.rlast, hl);
        end
        if (s_axi.rready) begin
          chk("rid", s_axi.rid, id);
          chk("rdata", s_axi.rdata, ebuf[beat]);
          chk("rresp", s_axi.rresp, er);
          chk("rlast", s_axi.rlast, beat == int'(len));
          beat++;
          held = 0;
        end else begin
          held = 1;
          hd = s_axi.rdata;
          hi = s_axi.rid;
          hr = s_axi.rresp;
          hl = s_axi.rlast;
        end
      end
      @(posedge clk); #1;
      t++;
      s_axi.rready = rnd ? 1'($urandom % 2) : 1'b1;
    end
    s_axi.rready = 1'b0;
    if (beat <= int'(len)) timeout("r_beats");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    s_axi.awid = '0;
    s_axi.awaddr = '0;
    s_axi.awlen = '0;
    s_axi.awatop = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;
    s_axi.wstrb = '0;
    s_axi.wlast = 1'b0;
    s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.arid = '0;
    s_axi.araddr = '0;
    s_axi.arlen = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;

    vecs[0] = '{64'h00, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF,
                OK, OK, 64'h0F0F_0F0F_0F0F_0F0F};
    vecs[1] = '{64'h08, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF,
                OK, OK, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[2] = '{64'h08, 64'h1111_1111_1111_1111, 8'h81,
                OK, OK, 64'h11AD_BEEF_CAFE_F011};
    vecs[3] = '{64'h0F, 64'h0, 8'h0F,
                OK, OK, 64'h11AD_BEEF_0000_0000};
    vecs[4] = '{64'h78, 64'h0123_4567_89AB_CDEF, 8'hFF,
                OK, OK, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{64'h80, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF,
                DE, DE, 64'h0};
    vecs[6] = '{64'h1000, 64'h5555_5555_5555_5555, 8'hFF,
                DE, DE, 64'h0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", s_axi.awready, 0);
    chk("rst_arready", s_axi.arready, 0);
    chk("rst_wready", s_axi.wready, 0);
    chk("rst_bvalid", s_axi.bvalid, 0);
    chk("rst_rvalid", s_axi.rvalid, 0);
    chk("rst_rdata", s_axi.rdata, 0);
    chk("rst_rlast", s_axi.rlast, 0);
    chk("rst_bresp", s_axi.bresp, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", s_axi.arready, 1);
    @(posedge clk); #1;

    // Single-beat write/read vectors
    foreach (vecs[i]) begin
      wbuf[0] = vecs[i].wdata;
      sbuf[0] = vecs[i].wstrb;
      wr(4'd1, vecs[i].addr, 8'd0, 6'd0, vecs[i].bresp, 0);
      ebuf[0] = vecs[i].rdata;
      rd(4'd2, vecs[i].addr, 8'd0, vecs[i].rresp, 0, 0);
    end
    // Out-of-range writes must not alias onto word 0 or 15
    ebuf[0] = 64'h0F0F_0F0F_0F0F_0F0F;
    rd(4'd2, 64'h00, 8'd0, OK, 0, 0);
    ebuf[0] = 64'h0123_4567_89AB_CDEF;
    rd(4'd2, 64'h78, 8'd0, OK, 0, 0);

    // 4-beat burst
    wbuf[0] = 64'h11; wbuf[1] = 64'h22;
    wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    for (int b = 0; b < 4; b++) sbuf[b] = 8'hFF;
    wr(4'd5, 64'h10, 8'd3, 6'd0, OK, 0);
    for (int b = 0; b < 4; b++) ebuf[b] = wbuf[b];
    rd(4'd3, 64'h10, 8'd3, OK, 0, 0);

    // Partial strobe over all-ones
    wbuf[0] = '1; sbuf[0] = 8'hFF;
    wr(4'd1, 64'h0, 8'd0, 6'd0, OK, 0);
    wbuf[0] = '0; sbuf[0] = 8'h0F;
    wr(4'd1, 64'h0, 8'd0, 6'd0, OK, 0);
    ebuf[0] = 64'hFFFF_FFFF_0000_0000;
    rd(4'd1, 64'h0, 8'd0, OK, 0, 0);

    // Out-of-range 2-beat read
    ebuf[0] = '0; ebuf[1] = '0;
    rd(4'd7, 64'h80, 8'd1, DE, 0, 0);

    // Atomic: B SLVERR then one R SLVERR beat, memory untouched
    wbuf[0] = 64'hBAD; sbuf[0] = 8'hFF;
    wr(4'd9, 64'h10, 8'd0, 6'h31, SE, 0);
    ebuf[0] = '0;
    rd(4'd9, 64'h0, 8'd0, SE, 0, 1);
    ebuf[0] = 64'h11;
    rd(4'd1, 64'h10, 8'd0, OK, 0, 0);

    // Simultaneous AW+AR with random back-pressure
    wbuf[0] = 64'hA1; wbuf[1] = 64'hA2;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    s_axi.arvalid = 1'b1;
    s_axi.arid    = 4'd4;
    s_axi.araddr  = 64'h10;
    s_axi.arlen   = 8'd1;
    wr(4'd6, 64'h10, 8'd1, 6'd0, OK, 1);
    ebuf[0] = 64'hA1; ebuf[1] = 64'hA2;
    rd(4'd4, 64'h10, 8'd1, OK, 1, 0);

    // Reset during beat 2 of a 4-beat read
    s_axi.arvalid = 1'b1;
    s_axi.arid    = 4'd2;
    s_axi.araddr  = 64'h10;
    s_axi.arlen   = 8'd3;
    s_axi.rready  = 1'b1;
    @(negedge clk);
    chk("mr_arready", s_axi.arready, 1);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    @(negedge clk);
    chk("mr_beat1", s_axi.rdata, 64'hA1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_beat2", s_axi.rdata, 64'hA2);
    rst = 1'b1;
    s_axi.rready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_rvalid", s_axi.rvalid, 0);
    chk("mr_rdata", s_axi.rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_axi.arvalid = 1'b1;
    @(negedge clk);
    chk("mr_arready_after", s_axi.arready, 1);
    s_axi.arvalid = 1'b0;
    @(posedge clk); #1;
    ebuf[0] = 64'hA1; ebuf[1] = 64'hA2;
    ebuf[2] = 64'h33; ebuf[3] = 64'h44;
    rd(4'd2, 64'h10, 8'd3, OK, 0, 0);

    // Burst wrapping from word 15 to word 0
    wbuf[0] = 64'hC0DE_0001; wbuf[1] = 64'hC0DE_0002;
    wr(4'd3, 64'h78, 8'd1, 6'd0, OK, 0);
    ebuf[0] = wbuf[0]; ebuf[1] = wbuf[1];
    rd(4'd3, 64'h78, 8'd1, OK, 0, 0);
    ebuf[0] = 64'hC0DE_0002;
    rd(4'd3, 64'h00, 8'd0, OK, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_scratchpad_responder.md
AXI_SCRATCHPAD_RESPONDER -- requirements
Module: axi_scratchpad_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, the AXI ID width of the CVA6 initiator port.
REQ-002 SHALL have parameter MEM_WORDS, default 512, the number of 64-bit memory words (power of 2, ≥2).
REQ-003 clock_i  in  1  single clock; all logic on rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 s_axi_awid  in  ID_WIDTH  write ID.
REQ-006 s_axi_awaddr  in  64  write byte address; bits [2:0] ignored.
REQ-007 s_axi_awlen  in  8  write beats minus 1; INCR only, 8-byte beats.
REQ-008 s_axi_awatop  in  6  AXI5 atomic opcode; 0 = plain write.
REQ-009 s_axi_awvalid  in  1  AW valid.
REQ-010 s_axi_awready  out  1  AW ready.
REQ-011 s_axi_wdata  in  64  write data.
REQ-012 s_axi_wstrb  in  8  byte enables.
REQ-013 s_axi_wlast  in  1  last write beat.
REQ-014 s_axi_wvalid  in  1  W valid.
REQ-015 s_axi_wready  out  1  W ready.
REQ-016 s_axi_bid  out  ID_WIDTH  response ID (= captured awid).
REQ-017 s_axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
REQ-018 s_axi_bvalid  out  1  B valid.
REQ-019 s_axi_bready  in  1  B ready.
REQ-020 s_axi_arid  in  ID_WIDTH  read ID.
REQ-021 s_axi_araddr  in  64  read byte address; bits [2:0] ignored.
REQ-022 s_axi_arlen  in  8  read beats minus 1; INCR only.
REQ-023 s_axi_arvalid  in  1  AR valid.
REQ-024 s_axi_arready  out  1  AR ready.
REQ-025 s_axi_rid  out  ID_WIDTH  read ID.
REQ-026 s_axi_rdata  out  64  read data.
REQ-027 s_axi_rresp  out  2  read response code.
REQ-028 s_axi_rlast  out  1  last read beat.
REQ-029 s_axi_rvalid  out  1  R valid.
REQ-030 s_axi_rready  in  1  R ready.

Function
REQ-031 SHALL use FSM IDLE, WRITE, WRESP, READ, ATOP_R; exactly one transaction in flight.
REQ-032 IDLE: awready=1 and arready=0 when awvalid=1; else arready=1; simultaneous AW+AR -> AW accepted, AR held off.
REQ-033 AW handshake -> capture id/addr/len/atop, go WRITE; AR handshake -> capture, go READ; first beat rvalid next cycle.
REQ-034 Out-of-range (awaddr/araddr ≥ MEM_WORDS*8) evaluated once at address handshake -> DECERR for whole burst, no memory write, rdata=0.
REQ-035 Word index = addr[$clog2(MEM_WORDS)+2:3], +1 per beat, wraps modulo MEM_WORDS.
REQ-036 WRITE: wready=1; each W handshake with atop=0 and in range writes bytes where wstrb=1; wlast handshake -> WRESP next cycle; termination on wlast only, awlen not checked.
REQ-037 atop≠0: W beats drained, no memory write, bresp=SLVERR.
REQ-038 WRESP: bvalid=1, bid=captured id, held stable until bready; handshake -> ATOP_R if atop[5]=1, else IDLE.
REQ-039 READ: arlen+1 beats, rlast on final; rid/rdata/rresp/rlast stable while rvalid=1 and rready=0; 1 beat/cycle when rready=1; final handshake -> IDLE.
REQ-040 ATOP_R: awlen+1 R beats, rid=captured awid, rresp=SLVERR, rdata=0, rlast on final; then IDLE.
REQ-041 Write-then-read same address returns written data (no stale read).

Reset
REQ-042 reset_i=1 -> IDLE, all ready/valid outputs 0, rdata/rresp/bresp/rlast/ids 0; in-flight burst aborted without response; memory contents retained.

Verification
REQ-043 AW addr 0x10 len 3, 4 beats 0x11..0x44 strb 0xFF -> B OKAY, bid=awid; AR addr 0x10 len 3 -> 0x11,0x22,0x33,0x44, rlast beat 4.
REQ-044 Write 0xFFFF_FFFF_FFFF_FFFF then wstrb 0x0F data 0 to 0x0 -> read 0xFFFF_FFFF_0000_0000.
REQ-045 AR addr MEM_WORDS*8, len 1 -> 2 beats DECERR, rdata 0; AW out of range -> DECERR, memory unchanged.
REQ-046 AW atop 0x31, len 0, 1 W beat -> B SLVERR, then 1 R beat SLVERR rlast=1, memory unchanged.
REQ-047 AW+AR same cycle, bready/rready toggled randomly -> write completes first, outputs stable while stalled.
REQ-048 reset_i mid read burst (beat 2 of 4) -> rvalid 0 next cycle, arready 1 once AR valid.
